seven_seg_scanner: RTL and testbench

Parametrised time-multiplexed driver for common-anode seven-segment displays. It is the generalised successor to the fixed 4-digit scanner and sits between the calculator datapath and the Basys3 `seg`/`dp`/`an` pins. It adds:
- configurable digit count and scan rate;
- a tear-free frame snapshot;
- hex glyphs;
- leading-zero blanking, per-digit decimal point and blink;
- PWM brightness and a registered, ghost-free output stage.

---
 rtl/seven_seg_scanner.sv | 190 +++++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for common-anode seven-segment displays.
//
// Scans NUM_DIGITS digits, one slot of TICK_CYCLES clocks each. A whole frame is shown
// from a snapshot of digits/dp_in/blink_en taken at the start of the frame, so mid-frame
// input changes never tear the display. Supports hex glyphs, leading-zero blanking,
// per-digit decimal point and blink, PWM brightness, and a one-cycle all-off guard at
// the start of each slot to avoid ghosting. All outputs are registered.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   display      global enable (0: all segments and anodes off)
//   digits       4 bits per digit, digit 0 rightmost at [3:0]
//   dp_in        per-digit decimal point request, active-high
//   blink_en     per-digit blink request, active-high
//   hex_mode     1: 10..15 as A,b,C,d,E,F; 0: 10..15 as a dash
//   lz_blank     1: blank leading zeros (digit 0 always shown)
//   brightness   PWM on-level, duty = (brightness+1)/2^BRIGHT_W
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//   an           anode enables, active-low
//   frame_start  one-cycle pulse when the scan returns to digit 0
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned TICK_CYCLES  = 100000,
  parameter int unsigned BLINK_FRAMES = 125,
  parameter int unsigned BRIGHT_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    display,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int unsigned TickW  = $clog2(TICK_CYCLES);
  localparam int unsigned SlotW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_CYCLES - 1);
  localparam logic [SlotW-1:0]  SlotLast  = SlotW'(NUM_DIGITS - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

  localparam logic [6:0] SegOff = 7'h7F;
  localparam logic [6:0] Dash   = 7'b0111111;

  logic [TickW-1:0]        tick_q;
  logic [SlotW-1:0]        slot_q;
  logic [BRIGHT_W-1:0]     pwm_q;
  logic [BlinkW-1:0]       blink_cnt_q;
  logic                    blink_phase_q;
  logic                    first_q;
  logic [4*NUM_DIGITS-1:0] snap_digits_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;
  logic [NUM_DIGITS-1:0]   snap_blink_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic                    frame_start_q;

  logic                    tick_wrap;
  logic                    frame_wrap;
  logic                    snap_load;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    upper_zero;
  logic                    blanked;
  logic                    lit;
  logic                    on;
  logic [3:0]              cur_digit;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [6:0]              seg_d;
  logic                    dp_d;

  function automatic logic [6:0] glyph(input logic [3:0] v, input logic hex);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
    endcase
    if (!hex && (v > 4'd9)) g = Dash;
    return g;
  endfunction

  assign tick_wrap  = (tick_q == TickLast);
  assign frame_wrap = tick_wrap && (slot_q == SlotLast);
  // The first edge after reset also loads, so frame 0 shows the current inputs.
  assign snap_load  = frame_wrap || first_q;
  assign cur_digit  = snap_digits_q[4*slot_q +: 4];

  // lz_mask[i] set when snapshot digits i..NUM_DIGITS-1 are all zero (i >= 1).
  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (snap_digits_q[4*i +: 4] == 4'h0);
      lz_mask[i] = upper_zero;
    end
  end

  always_comb begin
    blanked = (lz_blank && lz_mask[slot_q]) || (blink_phase_q && snap_blink_q[slot_q]);
    lit     = display && !blanked;
    // tick_q == 0 is the ghost-guard cycle at the start of each slot.
    on      = lit && (tick_q != '0) && (pwm_q <= brightness);
    an_d    = '1;
    seg_d   = SegOff;
    dp_d    = 1'b1;
    if (lit) seg_d = glyph(cur_digit, hex_mode);
    if (on) begin
      an_d = ~(NUM_DIGITS'(1) << slot_q);
      dp_d = ~snap_dp_q[slot_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q        <= '0;
      slot_q        <= '0;
      pwm_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      first_q       <= 1'b1;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_blink_q  <= '0;
      an_q          <= '1;
      seg_q         <= SegOff;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      first_q <= 1'b0;
      pwm_q   <= pwm_q + 1'b1;

      if (tick_wrap) begin
        tick_q <= '0;
        slot_q <= (slot_q == SlotLast) ? '0 : slot_q + 1'b1;
      end else begin
        tick_q <= tick_q + 1'b1;
      end

      if (frame_wrap) begin
        if (blink_cnt_q == BlinkLast) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end

      if (snap_load) begin
        snap_digits_q <= digits;
        snap_dp_q     <= dp_in;
        snap_blink_q  <= blink_en;
      end

      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_wrap;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (4 digits, 8-cycle slots, 2-bit brightness,
// 2-frame blink). A cycle-count reference model checks every output on every cycle,
// alongside table-driven frame vectors and hand-written corner-case sequences.
module tb_seven_seg_scanner;

  localparam int N     = 4;
  localparam int T     = 8;
  localparam int BW    = 2;
  localparam int BF    = 2;
  localparam int FRAME = N * T;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110, DASH = 7'b0111111, OFF = 7'h7F;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          display = 1'b1;
  logic [15:0]   digits = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blink_en = '0;
  logic          hex_mode = 1'b0;
  logic          lz_blank = 1'b0;
  logic [BW-1:0] brightness = 2'd3;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_start;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS  (N),
    .TICK_CYCLES (T),
    .BLINK_FRAMES(BF),
    .BRIGHT_W    (BW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .display    (display),
    .digits     (digits),
    .dp_in      (dp_in),
    .blink_en   (blink_en),
    .hex_mode   (hex_mode),
    .lz_blank   (lz_blank),
    .brightness (brightness),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_start(frame_start)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] v, input logic hex);
    logic [6:0] tbl [16];
    tbl = '{G0, G1, G2, G3, G4, G5, G6, G7, G8, G9, GA, GB, GC, GD, GE, GF};
    if (!hex && v > 4'd9) return DASH;
    return tbl[v];
  endfunction

  // Reference model: state is derived from the number of clock edges since reset release.
  // Outputs seen after edge c+1 are a function of cycle c.
  int          mc = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_blk = '0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = OFF;
  logic        exp_dp = 1'b1;
  logic        exp_fs = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc <= 0;
      m_dig <= '0;
      m_dp <= '0;
      m_blk <= '0;
      exp_an <= 4'hF;
      exp_seg <= OFF;
      exp_dp <= 1'b1;
      exp_fs <= 1'b0;
    end else begin : model
      int tk, sl, fr;
      bit ph, allz, blk, lt, on;
      tk = mc % T;
      sl = (mc / T) % N;
      fr = mc / FRAME;
      ph = ((fr / BF) % 2) == 1;
      allz = 1'b1;
      for (int i = sl; i < N; i++) if (m_dig[4*i +: 4] != 4'h0) allz = 1'b0;
      blk = (lz_blank && sl != 0 && allz) || (ph && m_blk[sl]);
      lt = display && !blk;
      on = lt && (tk != 0) && ((mc % (1 << BW)) <= int'(brightness));
      exp_seg <= lt ? ref_glyph(m_dig[4*sl +: 4], hex_mode) : OFF;
      exp_an <= on ? 4'(~(4'b0001 << sl)) : 4'hF;
      exp_dp <= on ? ~m_dp[sl] : 1'b1;
      exp_fs <= (mc % FRAME) == FRAME - 1;
      if (mc == 0 || (mc % FRAME) == FRAME - 1) begin
        m_dig <= digits;
        m_dp <= dp_in;
        m_blk <= blink_en;
      end
      mc <= mc + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("stream{fs,dp,seg,an}", {19'd0, frame_start, dp, seg, an},
            {19'd0, exp_fs, exp_dp, exp_seg, exp_an});
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [3:0] an_log [0:160];
  logic       fs_log [0:160];

  // Sample k = 1..n, k being the number of edges since reset release.
  task automatic record(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      an_log[k] = an;
      fs_log[k] = frame_start;
    end
  endtask

  function automatic int count_an(input logic [3:0] pat, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (an_log[k] == pat) c++;
    return c;
  endfunction

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        hex;
    logic        lz;
    logic [3:0]  lit;
    logic [27:0] segs;  // {seg3, seg2, seg1, seg0}
    logic [3:0]  dps;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_en = 1'b1;

    vecs[0] = '{16'h4321, 4'b0000, 1'b0, 1'b0, 4'b1111, {G4, G3, G2, G1}, 4'b0000};
    vecs[1] = '{16'h000A, 4'b0000, 1'b0, 1'b0, 4'b1111, {G0, G0, G0, DASH}, 4'b0000};
    vecs[2] = '{16'h000A, 4'b0000, 1'b1, 1'b0, 4'b1111, {G0, G0, G0, GA}, 4'b0000};
    vecs[3] = '{16'h000F, 4'b0000, 1'b1, 1'b0, 4'b1111, {G0, G0, G0, GF}, 4'b0000};
    vecs[4] = '{16'h0050, 4'b0000, 1'b0, 1'b1, 4'b0011, {OFF, OFF, G5, G0}, 4'b0000};
    vecs[5] = '{16'h0000, 4'b0000, 1'b0, 1'b1, 4'b0001, {OFF, OFF, OFF, G0}, 4'b0000};
    vecs[6] = '{16'h1111, 4'b0100, 1'b0, 1'b0, 4'b1111, {G1, G1, G1, G1}, 4'b0100};
    vecs[7] = '{16'hBCDE, 4'b1010, 1'b1, 1'b0, 4'b1111, {GB, GC, GD, GE}, 4'b1010};
    vecs[8] = '{16'h7698, 4'b0000, 1'b0, 1'b1, 4'b1111, {G7, G6, G9, G8}, 4'b0000};
    vecs[9] = '{16'h0305, 4'b0001, 1'b1, 1'b1, 4'b0111, {OFF, G3, G0, G5}, 4'b0001};

    // Table: one full frame per vector, recording which slots lit and what they showed.
    for (int v = 0; v < 10; v++) begin
      logic [3:0]  lit_o;
      logic [27:0] segs_o;
      logic [3:0]  dps_o;
      digits = vecs[v].digits;
      dp_in = vecs[v].dp;
      hex_mode = vecs[v].hex;
      lz_blank = vecs[v].lz;
      do_reset();
      lit_o = '0;
      segs_o = {4{OFF}};
      dps_o = '0;
      for (int k = 1; k <= FRAME; k++) begin
        @(negedge clk);
        for (int s = 0; s < N; s++) begin
          if (an == 4'(~(4'b0001 << s))) begin
            lit_o[s] = 1'b1;
            segs_o[7*s +: 7] = seg;
            if (!dp) dps_o[s] = 1'b1;
          end
        end
      end
      check($sformatf("vec%0d_lit", v), {28'd0, lit_o}, {28'd0, vecs[v].lit});
      check($sformatf("vec%0d_segs", v), {4'd0, segs_o}, {4'd0, vecs[v].segs});
      check($sformatf("vec%0d_dp", v), {28'd0, dps_o}, {28'd0, vecs[v].dps});
    end
    hex_mode = 1'b0;
    lz_blank = 1'b0;
    dp_in = '0;

    // Scan order, guard cycle, active cycles per slot and frame_start period.
    digits = 16'h4321;
    do_reset();
    record(2 * FRAME);
    check("order_k2", {28'd0, an_log[2]}, 32'hE);
    check("guard_k9", {28'd0, an_log[9]}, 32'hF);
    check("order_k10", {28'd0, an_log[10]}, 32'hD);
    check("order_k18", {28'd0, an_log[18]}, 32'hB);
    check("order_k26", {28'd0, an_log[26]}, 32'h7);
    check("active_s0", count_an(4'b1110, FRAME + 1, 2 * FRAME), 7);
    check("active_s1", count_an(4'b1101, FRAME + 1, 2 * FRAME), 7);
    check("active_s2", count_an(4'b1011, FRAME + 1, 2 * FRAME), 7);
    check("active_s3", count_an(4'b0111, FRAME + 1, 2 * FRAME), 7);
    begin
      int first_fs = -1, second_fs = -1;
      for (int k = 1; k <= 2 * FRAME; k++) begin
        if (fs_log[k] === 1'b1) begin
          if (first_fs < 0) first_fs = k;
          else if (second_fs < 0) second_fs = k;
        end
      end
      check("fs_first", first_fs, FRAME);
      check("fs_period", second_fs - first_fs, FRAME);
    end

    // Async reset while slot 2 is lit: outputs blank before the next clock edge.
    begin
      int n = 0;
      while (an !== 4'b1011 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("rst_reach_slot2", n < 100, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_an", {28'd0, an}, 32'hF);
      check("rst_seg", {25'd0, seg}, {25'd0, OFF});
      check("rst_dp", {31'd0, dp}, 32'd1);
      check("rst_fs", {31'd0, frame_start}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (an === 4'hF && n < 50);
      check("rst_first_active", {28'd0, an}, 32'hE);
    end

    // Snapshot: a mid-frame change is invisible until the next frame.
    digits = 16'h1111;
    do_reset();
    repeat (12) @(negedge clk);
    digits = 16'h2222;
    begin
      int n = 0, stale = 0, bad = 0, litc = 0;
      bit got = 1'b0;
      while (!got && n < 100) begin
        @(negedge clk);
        n++;
        if (frame_start) got = 1'b1;
        else if (an != 4'hF && seg != G1) stale++;
      end
      check("snap_fs_seen", {31'd0, got}, 32'd1);
      check("snap_old_frame", stale, 0);
      for (int k = 0; k < FRAME; k++) begin
        @(negedge clk);
        if (an != 4'hF) begin
          litc++;
          if (seg != G2) bad++;
        end
      end
      check("snap_new_frame", bad, 0);
      check("snap_new_lit", litc, 4 * (T - 1));
    end

    // Brightness: with T a multiple of 2^BW the PWM phase repeats per slot; level 0 leaves
    // only tick 4 of each slot, level 1 leaves ticks 1, 4 and 5.
    digits = 16'h4321;
    brightness = 2'd0;
    do_reset();
    record(2 * FRAME);
    check("bright0_lit", FRAME - count_an(4'hF, FRAME + 1, 2 * FRAME), 4);
    brightness = 2'd1;
    do_reset();
    record(2 * FRAME);
    check("bright1_lit", FRAME - count_an(4'hF, FRAME + 1, 2 * FRAME), 12);
    brightness = 2'd3;

    // Blink digit 0: lit frames 0-1, dark 2-3; digit 1 always lit.
    blink_en = 4'b0001;
    do_reset();
    record(4 * FRAME);
    for (int f = 0; f < 4; f++) begin
      check($sformatf("blink_d0_f%0d", f),
            count_an(4'b1110, f * FRAME + 1, (f + 1) * FRAME), (f < 2) ? 7 : 0);
      check($sformatf("blink_d1_f%0d", f),
            count_an(4'b1101, f * FRAME + 1, (f + 1) * FRAME), 7);
    end
    blink_en = '0;

    // Random inputs against the reference model.
    for (int it = 0; it < 60; it++) begin
      logic [15:0] d;
      d = 16'($urandom);
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 2) == 0) d[4*i +: 4] = 4'h0;
      digits = d;
      dp_in = 4'($urandom);
      blink_en = 4'($urandom);
      hex_mode = 1'($urandom);
      lz_blank = 1'($urandom);
      brightness = BW'($urandom);
      display = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 9) == 0) do_reset();
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
